// File: rtl/cpu_state_dumper_if.sv
// Dump output stream: one beat per handshake (valid & ready on a rising edge).
interface cpu_state_dumper_if;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [1:0]  out_tag_o;
    logic [4:0]  out_idx_o;
    logic [31:0] out_data_o;

    // Dump unit drives the beat, sink returns ready.
    modport master (
        output out_valid_o,
        output out_tag_o,
        output out_idx_o,
        output out_data_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_tag_o,
        input  out_idx_o,
        input  out_data_o,
        output out_ready_i
    );
endinterface

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: detects the end-of-program marker write, freezes the cycle
// counter and streams {cycle count, registers, memory words, end marker} over
// a valid/ready port using spare combinational read ports on RF and DMEM.
module cpu_state_dumper #(
    parameter int          NUM_REGS = 32,
    parameter int          NUM_MEM  = 32,
    parameter int          HALT_REG = 30,
    parameter logic [31:0] MAGIC    = 32'h3345
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wb_we_i,
    input  logic [4:0]         wb_addr_i,
    input  logic [31:0]        wb_data_i,
    input  logic               dump_req_i,
    output logic [4:0]         reg_addr_o,
    input  logic [31:0]        reg_data_i,
    output logic [4:0]         mem_idx_o,
    input  logic [31:0]        mem_data_i,
    cpu_state_dumper_if.master out_if,
    output logic               halt_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_FETCH, ST_SEND, ST_END, ST_DONE
    } state_t;

    localparam logic [1:0] TAG_CNT = 2'd0;
    localparam logic [1:0] TAG_REG = 2'd1;
    localparam logic [1:0] TAG_MEM = 2'd2;
    localparam logic [1:0] TAG_END = 2'd3;

    localparam logic [4:0] REG_LAST  = 5'(NUM_REGS - 1);
    localparam logic [4:0] MEM_LAST  = 5'(NUM_MEM - 1);
    localparam logic [4:0] HALT_ADDR = 5'(HALT_REG);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  idx_q, idx_d;
    logic        seg_q, seg_d;      // 0 = register segment, 1 = memory segment
    logic        halt_q, halt_d;

    logic        halt_hit;
    logic        trigger;
    logic        beat_valid;
    logic        hshake;
    logic [4:0]  last_idx;

    // Halt detection and the cycle counter; the halt edge itself does not count.
    always_comb begin
        halt_hit = wb_we_i && (wb_addr_i == HALT_ADDR) && (wb_data_i == MAGIC);
        halt_d   = halt_q | halt_hit;
        cnt_d    = cnt_q;
        if (!halt_q && !halt_hit && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Dump sequencer: header, FETCH/SEND pairs per word, end marker.
    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        idx_d    = idx_q;
        data_d   = data_q;
        trigger  = halt_hit | dump_req_i;
        last_idx = seg_q ? MEM_LAST : REG_LAST;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (trigger) begin
                    state_d = ST_HDR;
                    data_d  = cnt_q;
                    seg_d   = 1'b0;
                    idx_d   = 5'd0;
                end
            end
            ST_HDR: begin
                if (hshake) begin
                    state_d = ST_FETCH;
                    seg_d   = 1'b0;
                    idx_d   = 5'd0;
                end
            end
            ST_FETCH: begin
                data_d  = seg_q ? mem_data_i : reg_data_i;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (hshake) begin
                    if (idx_q != last_idx) begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_FETCH;
                    end else if (!seg_q) begin
                        seg_d   = 1'b1;
                        idx_d   = 5'd0;
                        state_d = ST_FETCH;
                    end else begin
                        idx_d   = 5'd0;
                        data_d  = 32'd0;
                        state_d = ST_END;
                    end
                end
            end
            ST_END: begin
                if (hshake) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: payload lives in data_q so it holds while the sink stalls.
    always_comb begin
        beat_valid = (state_q == ST_HDR) || (state_q == ST_SEND) || (state_q == ST_END);
        hshake     = beat_valid && out_if.out_ready_i;

        out_if.out_valid_o = beat_valid;
        out_if.out_data_o  = data_q;
        out_if.out_idx_o   = (state_q == ST_SEND) ? idx_q : 5'd0;
        out_if.out_tag_o   = TAG_CNT;
        if (state_q == ST_SEND) begin
            out_if.out_tag_o = seg_q ? TAG_MEM : TAG_REG;
        end else if (state_q == ST_END) begin
            out_if.out_tag_o = TAG_END;
        end

        reg_addr_o = ((state_q == ST_FETCH) && !seg_q) ? idx_q : 5'd0;
        mem_idx_o  = ((state_q == ST_FETCH) &&  seg_q) ? idx_q : 5'd0;

        halt_o = halt_q;
        busy_o = beat_valid || (state_q == ST_FETCH);
        done_o = (state_q == ST_DONE);
    end

    // State registers; asynchronous reset aborts any dump in progress.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 32'd0;
            data_q  <= 32'd0;
            idx_q   <= 5'd0;
            seg_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            halt_q  <= halt_d;
        end
    end

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Bench for cpu_state_dumper: RF/DMEM models, beat scoreboard, directed sequences.
`timescale 1ns/1ps
module tb_cpu_state_dumper;
    localparam logic [31:0] MAGIC = 32'h3345;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        dump_req = 1'b0;
    logic [4:0]  reg_addr, mem_idx;
    logic [31:0] reg_data, mem_data;
    logic        halt, busy, done;

    logic [31:0] regs [32];
    logic [31:0] dmem [32];

    cpu_state_dumper_if dif();

    assign reg_data = regs[reg_addr];
    assign mem_data = dmem[mem_idx];

    always #5 clk = ~clk;

    cpu_state_dumper dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .wb_we_i    (wb_we),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .dump_req_i (dump_req),
        .reg_addr_o (reg_addr),
        .reg_data_i (reg_data),
        .mem_idx_o  (mem_idx),
        .mem_data_i (mem_data),
        .out_if     (dif),
        .halt_o     (halt),
        .busy_o     (busy),
        .done_o     (done)
    );

    typedef struct packed {
        logic [1:0]  tag;
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        exp_halt;
    } vec_t;

    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    edges = 0;
    int    beats = 0;
    int    hdr_c = 0, reg0_c = 0, mem0_c = 0, end_c = 0;
    logic  rnd_ready = 1'b0;
    logic  ready_fix = 1'b1;
    logic  ready_r = 1'b0;

    assign dif.out_ready_i = ready_r;

    // Edge counters: cyc counts all edges, edges counts edges since reset release.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) edges = 0;
        else        edges++;
    end

    // Sink ready: fixed level or ~40% random.
    always @(posedge clk) begin
        #1;
        ready_r = rnd_ready ? ($urandom_range(0, 99) < 40) : ready_fix;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: scoreboard compare on handshake, stability check while stalled.
    beat_t last_b;
    logic  held = 1'b0;
    always @(negedge clk) begin : mon
        beat_t cur;
        beat_t e;
        cur = {dif.out_tag_o, dif.out_idx_o, dif.out_data_o};
        if (!rst_n) begin
            held = 1'b0;
        end else if (dif.out_valid_o) begin
            if (held) check("stall_hold", 64'(cur), 64'(last_b));
            if (dif.out_ready_i) begin
                held = 1'b0;
                beats++;
                if (cur.tag == 2'd0) hdr_c = cyc + 1;
                if (cur.tag == 2'd1 && cur.idx == 5'd0) reg0_c = cyc + 1;
                if (cur.tag == 2'd2 && cur.idx == 5'd0) mem0_c = cyc + 1;
                if (cur.tag == 2'd3) end_c = cyc + 1;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", cur);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat_t%0d_i%0d", e.tag, e.idx), 64'(cur), 64'(e));
                end
            end else begin
                held   = 1'b1;
                last_b = cur;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic push_dump(input logic [31:0] cnt);
        exp_q.push_back({2'd0, 5'd0, cnt});
        for (int i = 0; i < 32; i++) exp_q.push_back({2'd1, 5'(i), regs[i]});
        for (int j = 0; j < 32; j++) exp_q.push_back({2'd2, 5'(j), dmem[j]});
        exp_q.push_back({2'd3, 5'd0, 32'd0});
    endtask

    // Drive one trigger edge; t returns the trigger edge number.
    task automatic fire(input logic req, input logic hlt, input logic [31:0] exp_cnt, output int t);
        push_dump(exp_cnt);
        dump_req = req;
        if (hlt) begin
            wb_we   = 1'b1;
            wb_addr = 5'd30;
            wb_data = MAGIC;
        end
        t = cyc + 1;
        step();
        dump_req = 1'b0;
        wb_we    = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;
    endtask

    // Bounded wait for done_o; dc is the first cycle it is high.
    task automatic wait_done(output int dc);
        dc = -1;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (done) begin
                dc = cyc + 1;
                break;
            end
        end
        if (dc < 0) begin
            n_chk++;
            $display("FAIL done_timeout: got done_o=0 expected 1 within 3000 cycles");
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({dif.out_valid_o, dif.out_tag_o, dif.out_idx_o, dif.out_data_o,
                    reg_addr, mem_idx, halt, busy, done});
    endfunction

    initial begin
        vec_t vecs [4];
        int   t, dc, b0, fz;
        logic found;

        vecs[0] = '{we: 1'b1, addr: 5'd29, data: MAGIC,         exp_halt: 1'b0};
        vecs[1] = '{we: 1'b1, addr: 5'd30, data: 32'h0000_3346, exp_halt: 1'b0};
        vecs[2] = '{we: 1'b0, addr: 5'd30, data: MAGIC,         exp_halt: 1'b0};
        vecs[3] = '{we: 1'b1, addr: 5'd31, data: MAGIC,         exp_halt: 1'b0};

        for (int i = 0; i < 32; i++) begin
            regs[i] = 32'(i * 3);
            dmem[i] = 32'(100 + i);
        end

        // Reset with random inputs: every output 0.
        rst_n = 1'b0;
        #2;
        repeat (5) begin
            wb_we    = 1'($urandom);
            wb_addr  = 5'($urandom);
            wb_data  = $urandom;
            dump_req = 1'($urandom);
            step();
            check("reset_outputs", all_outs(), 64'd0);
        end
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; dump_req = 1'b0;
        rst_n = 1'b1;
        b0 = beats;
        repeat (200) step();
        check("idle_no_beats", 64'(beats - b0), 64'd0);
        check("idle_valid", 64'(dif.out_valid_o), 64'd0);

        // Non-halting writes from the vector table.
        foreach (vecs[k]) begin
            wb_we = vecs[k].we; wb_addr = vecs[k].addr; wb_data = vecs[k].data;
            step();
            wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
            check($sformatf("halt_vec%0d", k), 64'(halt), 64'(vecs[k].exp_halt));
        end
        fire(1'b1, 1'b0, 32'(edges), t);
        wait_done(dc);
        check("halt_after_req_dump", 64'(halt), 64'd0);

        // Halt-triggered dump at cycle 57 with ready tied high.
        do_reset(3);
        repeat (57) step();
        fire(1'b0, 1'b1, 32'd57, t);
        check("halt_set", 64'(halt), 64'd1);
        check("busy_set", 64'(busy), 64'd1);
        wait_done(dc);
        check("hdr_cycle",  64'(hdr_c),  64'(t + 1));
        check("reg0_cycle", 64'(reg0_c), 64'(t + 3));
        check("mem0_cycle", 64'(mem0_c), 64'(t + 67));
        check("end_cycle",  64'(end_c),  64'(t + 130));
        check("done_cycle", 64'(dc),     64'(t + 131));

        // Re-dump from DONE under random back-pressure: same frozen count.
        rnd_ready = 1'b1;
        b0 = beats;
        fire(1'b1, 1'b0, 32'd57, t);
        check("redump_done_clear", 64'(done), 64'd0);
        wait_done(dc);
        check("bp_beat_count", 64'(beats - b0), 64'd66);
        rnd_ready = 1'b0;

        // dump_req and halt on the same edge: exactly one dump.
        do_reset(2);
        repeat (20) step();
        b0 = beats;
        fire(1'b1, 1'b1, 32'(edges), t);
        wait_done(dc);
        repeat (20) step();
        check("collide_beats", 64'(beats - b0), 64'd66);
        check("collide_halt",  64'(halt), 64'd1);

        // Halt during a dump_req dump: completes once, counter frozen.
        do_reset(2);
        repeat (10) step();
        b0 = beats;
        fire(1'b1, 1'b0, 32'(edges), t);
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (beats - b0 >= 10) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("reach_beat10", 64'(found), 64'd1);
        fz = edges;
        wb_we = 1'b1; wb_addr = 5'd30; wb_data = MAGIC;
        step();
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        check("mid_halt_set", 64'(halt), 64'd1);
        wait_done(dc);
        repeat (20) step();
        check("mid_halt_beats", 64'(beats - b0), 64'd66);
        check("mid_halt_done",  64'(done), 64'd1);
        repeat (15) step();
        fire(1'b1, 1'b0, 32'(fz), t);
        wait_done(dc);

        // Reset during memory beat 5 aborts immediately.
        do_reset(2);
        repeat (15) step();
        fire(1'b1, 1'b0, 32'(edges), t);
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (dif.out_valid_o && dif.out_tag_o == 2'd2 && dif.out_idx_o == 5'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_mem5", 64'(found), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_valid",   64'(dif.out_valid_o), 64'd0);
        check("abort_outputs", all_outs(), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        b0 = beats;
        repeat (40) step();
        check("abort_no_beats", 64'(beats - b0), 64'd0);
        fire(1'b1, 1'b0, 32'd40, t);
        wait_done(dc);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_state_dumper.md
# cpu_state_dumper

On-chip architectural-state dump unit for the Pipe_CPU_1 pipeline. It detects the end-of-program marker write, freezes a cycle counter, and streams the elapsed-cycle count, all 32 registers and the first 32 data-memory words over a valid/ready port. This is the hardware side of what a simulation bench prints from hierarchical probes. It sits beside the register file and data memory, using one spare combinational read port on each, and never stalls the CPU.

## Interface
- NUM_REGS, 32, register-file entries dumped (index 0..NUM_REGS-1)
- NUM_MEM, 32, data-memory words dumped (word index 0..NUM_MEM-1)
- HALT_REG, 30, destination register whose write signals program end
- MAGIC, 32'h3345, value that, written to HALT_REG, signals program end
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- wb_we_i  in  1  write-back enable from WB stage
- wb_addr_i  in  5  write-back destination register
- wb_data_i  in  32  write-back data
- dump_req_i  in  1  software/debug dump request, level sampled each edge
- reg_addr_o  out  5  register-file read address (spare read port)
- reg_data_i  in  32  register-file read data, combinational from reg_addr_o
- mem_idx_o  out  5  data-memory word index (spare read port)
- mem_data_i  in  32  data-memory read data, combinational from mem_idx_o
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  sink accepts beat
- out_tag_o  out  2  0 = cycle count, 1 = register, 2 = memory word, 3 = end marker
- out_idx_o  out  5  register / word index of beat (0 for tags 0 and 3)
- out_data_o  out  32  beat payload
- halt_o  out  1  sticky: MAGIC written to HALT_REG
- busy_o  out  1  dump in progress
- done_o  out  1  last dump completed

## Operation
- Halt detect: on an edge with wb_we_i=1, wb_addr_i=HALT_REG and wb_data_i=MAGIC, set halt_o. It stays set until reset. Any other write does not set it, including MAGIC to another register or a write with wb_we_i=0.
- Cycle counter (32 bit): 0 at reset. Increments every edge while halt_o=0. Frozen once halt_o=1. Saturates at 32'hFFFFFFFF.
- Trigger: a halt-detect edge or dump_req_i=1 at an edge, in state IDLE or DONE. Both in the same edge produce one dump. Triggers in HDR/FETCH/SEND/END are ignored, including a halt detect; halt_o still sets and the counter still freezes.
- FSM states: IDLE, HDR, FETCH, SEND, END, DONE.
  - IDLE/DONE --trigger--> HDR. Captures the counter value at the trigger edge. The halt-detect edge itself does not increment.
  - HDR: beat tag 0, idx 0, data = captured count. On handshake -> FETCH with segment = REG, index 0.
  - FETCH: drive reg_addr_o or mem_idx_o with the current index; out_valid_o=0. Next edge latches reg_data_i/mem_data_i into out_data_o -> SEND.
  - SEND: beat tag 1 or 2, idx = index. On handshake:
    - if index < last: index+1 -> FETCH;
    - else if last register: segment = MEM, index 0 -> FETCH;
    - else -> END.
  - END: beat tag 3, idx 0, data 0. On handshake -> DONE.
  - DONE: done_o=1. A new trigger clears done_o and re-dumps.
- busy_o = 1 in HDR, FETCH, SEND, END.
- A handshake is out_valid_o & out_ready_i at a rising edge. While out_valid_o=1 and out_ready_i=0, tag, idx and data hold stable.
- The CPU is not stalled. A dump-requested snapshot of a running CPU is not atomic; a halt-triggered one is consistent provided the CPU makes no further writes.

## Timing
- Reset (async, immediate): state IDLE. All outputs 0: out_valid_o, out_tag_o, out_idx_o, out_data_o, reg_addr_o, mem_idx_o, halt_o, busy_o, done_o. Counter 0.
- Trigger at edge T: HDR valid from T+1. halt_o is high from T+1 when the trigger is a halt.
- With out_ready_i tied 1 (2 cycles per data beat):
  - register i beat valid in cycle T+3+2i;
  - memory j beat valid in cycle T+67+2j;
  - END beat valid in cycle T+130;
  - done_o high from T+131.
- With NUM_REGS=NUM_MEM=32 there are exactly 66 beats per dump.
- Back-pressure only stretches HDR/SEND/END; FETCH is always 1 cycle.
- Reset mid-dump aborts immediately. No further beats until a new trigger after reset release.

## Test plan
- Reset: hold rst_i=0 with random inputs -> all outputs 0; release with no trigger -> out_valid_o stays 0 for 200 cycles.
- Halt dump: preload R[i]=i*3, M[j]=100+j; write MAGIC to R30 at cycle 57 after reset -> halt_o high and beats in order:
  - tag0 data 57;
  - tag1 idx i data i*3 (R30 shows its preload);
  - tag2 idx j data 100+j;
  - tag3;
  - done_o at T+131 with out_ready_i=1.
- Non-halt writes: MAGIC to R29, 32'h3346 to R30, MAGIC to R30 with wb_we_i=0 -> halt_o stays 0, counter keeps counting.
- Back-pressure: random out_ready_i (~40% high) during a dump -> payload held stable while stalled, identical 66-beat sequence, no beat lost or duplicated.
- Collisions: dump_req_i and halt at the same edge -> exactly one dump; halt at beat 10 of a dump_req dump -> halt_o=1, counter frozen, in-progress dump completes, no second dump; dump_req_i in DONE -> second identical dump with the frozen count.
- Abort: assert rst_i=0 during memory beat 5 -> out_valid_o drops in the same cycle, all outputs 0; after release, dump_req_i gives a full dump with a count counted from the new reset.
